// File: rtl/snn_pkg.sv
// Shared definitions for the SNN top: frontend FSM states and image RAM geometry.
package snn_pkg;

    typedef enum logic [2:0] {
        LOAD,
        UNPACK,
        START,
        BUSY,
        SEND
    } state_t;

    localparam int unsigned IMG_BITS   = 784;
    localparam int unsigned RAM_ADDR_W = $clog2(IMG_BITS);

endpackage

// File: rtl/snn_frame_timeout.sv
// Idle-cycle counter for a partially received frame; expire pulses after
// TIMEOUT_CYC consecutive cycles with run high.
module snn_frame_timeout #(
    parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    assign expire = run && (cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/snn_uart_frontend.sv
// UART frame handler: unpacks a byte stream LSB-first into the image RAM,
// kicks the classifier and returns the digit as one UART byte.
module snn_uart_frontend
    import snn_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = 98,
    parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_rdy,
    input  logic [7:0]            rx_data,
    output logic                  ram_we,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic                  ram_wdata,
    output logic                  snn_start,
    input  logic                  snn_done,
    input  logic [3:0]            snn_digit,
    input  logic                  tx_rdy,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic [7:0]            led
);

    localparam int unsigned BYTE_W = RAM_ADDR_W - 3;
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(FRAME_BYTES - 1);

    state_t            state, state_nx;
    logic [BYTE_W-1:0] byte_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic              overrun;
    logic [3:0]        digit;
    logic [7:0]        tx_q;
    logic              idle_run;
    logic              idle_expire;

    // Idle time only matters once a frame has started.
    assign idle_run = (state == LOAD) && (byte_cnt != '0) && !rx_rdy;

    snn_frame_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (idle_run),
        .expire(idle_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (rx_rdy) state_nx = UNPACK;
            UNPACK:  if (bit_cnt == 3'd7) state_nx = (byte_cnt == LAST_BYTE) ? START : LOAD;
            START:   state_nx = BUSY;
            BUSY:    if (snn_done) state_nx = SEND;
            SEND:    if (tx_rdy) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = 1'b0;
        snn_start = 1'b0;
        tx_start  = 1'b0;
        case (state)
            UNPACK: begin
                ram_we    = 1'b1;
                ram_addr  = {byte_cnt, bit_cnt};
                ram_wdata = shift[0];
            end
            START:   snn_start = 1'b1;
            SEND:    tx_start  = tx_rdy;
            default: ;
        endcase
    end

    assign tx_data = tx_q;
    assign led     = {overrun, 3'b000, digit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            overrun  <= 1'b0;
            digit    <= '0;
            tx_q     <= '0;
        end else begin
            if (rx_rdy && state != LOAD) overrun <= 1'b1;
            case (state)
                LOAD: begin
                    if (rx_rdy) begin
                        shift <= rx_data;
                    end else if (idle_expire) begin
                        byte_cnt <= '0;
                    end
                end
                UNPACK: begin
                    shift   <= shift >> 1;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + BYTE_W'(1);
                    end
                end
                BUSY: begin
                    // tx_data is loaded on entry to SEND so it is valid with tx_start.
                    if (snn_done) begin
                        digit <= snn_digit;
                        tx_q  <= {4'h0, snn_digit};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_uart_frontend.sv
// Directed bench for snn_uart_frontend with a RAM-write scoreboard.
module tb_snn_uart_frontend;

    localparam int unsigned FRAME_BYTES = 98;
    localparam int unsigned TIMEOUT     = 200;
    localparam int unsigned LAST_ADDR   = FRAME_BYTES * 8 - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       ram_we;
    logic [9:0] ram_addr;
    logic       ram_wdata;
    logic       snn_start;
    logic       snn_done;
    logic [3:0] snn_digit;
    logic       tx_rdy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] led;

    snn_uart_frontend #(
        .FRAME_BYTES(FRAME_BYTES),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_rdy   (rx_rdy),
        .rx_data  (rx_data),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .snn_start(snn_start),
        .snn_done (snn_done),
        .snn_digit(snn_digit),
        .tx_rdy   (tx_rdy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .led      (led)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] addr;
        logic       b;
    } wr_t;

    wr_t        exp_q[$];
    int         errors    = 0;
    int         checks    = 0;
    int         start_cnt = 0;
    int         tx_cnt    = 0;
    int         byte_idx  = 0;
    logic [9:0] last_addr = '0;
    logic [7:0] tx_seen   = '0;
    logic       a5_bits[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    always @(negedge clk) begin
        wr_t e;
        if (ram_we) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write observed addr=%0d expected no write", ram_addr);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                assert (ram_addr === e.addr) else begin
                    errors++;
                    $error("FAIL wr_addr observed=%0d expected=%0d", ram_addr, e.addr);
                end
                checks++;
                assert (ram_wdata === e.b) else begin
                    errors++;
                    $error("FAIL wr_bit@%0d observed=%0b expected=%0b", e.addr, ram_wdata, e.b);
                end
                last_addr = ram_addr;
            end
        end
        if (snn_start) begin
            start_cnt++;
            checks++;
            assert (last_addr === 10'(LAST_ADDR) && exp_q.size() == 0) else begin
                errors++;
                $error("FAIL start_after_last observed last_addr=%0d pending=%0d expected=%0d/0",
                       last_addr, exp_q.size(), LAST_ADDR);
            end
        end
        if (tx_start) begin
            tx_cnt++;
            tx_seen = tx_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sample_byte(input int i);
        if (i == 0) return 8'hA5;
        return 8'(i * 37 + 11) ^ 8'(i >> 3);
    endfunction

    task automatic push_byte(input logic [7:0] b, input bit use_tbl);
        for (int n = 0; n < 8; n++) begin
            wr_t e;
            e.addr = 10'(byte_idx * 8 + n);
            e.b    = use_tbl ? a5_bits[n] : b[n];
            exp_q.push_back(e);
        end
        byte_idx = (byte_idx + 1 == FRAME_BYTES) ? 0 : byte_idx + 1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit use_tbl);
        push_byte(b, use_tbl);
        @(posedge clk) #1;
        rx_rdy  = 1'b1;
        rx_data = b;
        @(posedge clk) #1;
        rx_rdy = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    task automatic send_bytes(input int first, input int count);
        for (int i = first; i < first + count; i++) send_byte(sample_byte(i), i == 0);
    endtask

    task automatic finish_result(input logic [3:0] d, input int delay, input string tag);
        int t0;
        t0 = tx_cnt;
        @(posedge clk) #1;
        snn_done  = 1'b1;
        snn_digit = d;
        @(posedge clk) #1;
        snn_done  = 1'b0;
        snn_digit = 4'h0;
        repeat (delay) @(posedge clk);
        #1;
        chk({tag, "_tx_held"}, 32'(tx_cnt), 32'(t0));
        tx_rdy = 1'b1;
        for (int k = 0; k < 20 && tx_cnt == t0; k++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        tx_rdy = 1'b0;
        chk({tag, "_tx_pulses"}, 32'(tx_cnt), 32'(t0 + 1));
        chk({tag, "_tx_data"}, 32'(tx_seen), {24'h0, 4'h0, d});
        chk({tag, "_led_digit"}, 32'(led[3:0]), 32'(d));
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        rx_rdy    = 1'b0;
        rx_data   = 8'h00;
        snn_done  = 1'b0;
        snn_digit = 4'h0;
        tx_rdy    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ram", {21'h0, ram_we, ram_addr, ram_wdata}, 32'h0);
        chk("rst_ctrl", {30'h0, snn_start, tx_start}, 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_led", 32'(led), 32'h0);
        rst_n = 1'b1;

        // snn_done while idle must not touch the digit.
        @(posedge clk) #1;
        snn_done  = 1'b1;
        snn_digit = 4'h9;
        @(posedge clk) #1;
        snn_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("done_outside_busy", 32'(led), 32'h0);

        // Full frame, first byte 0xA5 checked against a literal bit table.
        send_bytes(0, FRAME_BYTES);
        repeat (3) @(posedge clk);
        #1;
        chk("frame1_starts", 32'(start_cnt), 32'd1);
        chk("frame1_drained", 32'(exp_q.size()), 32'd0);

        finish_result(4'h7, 50, "res7");
        chk("no_overrun_yet", 32'(led[7]), 32'd0);

        // Byte arriving while BUSY is dropped and flags overrun.
        send_bytes(0, FRAME_BYTES);
        @(posedge clk) #1;
        rx_rdy  = 1'b1;
        rx_data = 8'hFF;
        @(posedge clk) #1;
        rx_rdy = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("overrun_led", 32'(led[7]), 32'd1);
        chk("overrun_no_write", 32'(exp_q.size()), 32'd0);
        chk("frame2_starts", 32'(start_cnt), 32'd2);
        finish_result(4'h2, 0, "res2");

        // Idle just under the timeout keeps the frame; over it restarts at addr 0.
        send_bytes(0, 10);
        repeat (TIMEOUT - 10) @(posedge clk);
        send_bytes(10, 30);
        repeat (TIMEOUT + 1) @(posedge clk);
        byte_idx = 0;
        send_bytes(0, FRAME_BYTES);
        repeat (3) @(posedge clk);
        #1;
        chk("timeout_one_start", 32'(start_cnt), 32'd3);
        finish_result(4'h5, 3, "res5");

        // Reset during bit 3 of a byte abandons the frame immediately.
        send_bytes(0, 5);
        push_byte(8'h3C, 1'b0);
        @(posedge clk) #1;
        rx_rdy  = 1'b1;
        rx_data = 8'h3C;
        @(posedge clk) #1;
        rx_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we", 32'(ram_we), 32'd0);
        chk("rst_mid_unwritten", 32'(exp_q.size()), 32'd5);
        exp_q.delete();
        byte_idx = 0;
        chk("rst_mid_led", 32'(led), 32'h0);
        chk("rst_mid_tx_data", 32'(tx_data), 32'h0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        send_byte(8'hC3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("after_rst_drained", 32'(exp_q.size()), 32'd0);
        chk("after_rst_last_addr", 32'(last_addr), 32'd7);
        chk("total_starts", 32'(start_cnt), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
